des_cbc_ctrl: RTL and testbench
===============================

// Module: des_cbc_ctrl
// PURPOSE
//  Sequencer that drives one iterative DES core (17-cycle, Drdy/Krdy/BSY/Dvld handshake) as a CBC or ECB block engine.
//  Owns key and IV registers, XOR chaining and the stream valid/ready handshake, and recovers from a hung core by timeout.
//  Sits between the host/bus interface and the DES core; the core's EN is held at 1 and its RSTn is owned by this block.
// PARAMETERS
//  TIMEOUT  32  max cycles in WAIT before the core is declared hung (must be >= 18)
// PORTS
//  CLK        in   1   system clock
//  RSTn       in   1   asynchronous active-low reset
//  key_in     in   64  DES key, bit 1 = MSB; sampled when key_ld & cfg_rdy
//  key_ld     in   1   key load request
//  iv_in      in   64  CBC initial vector; sampled when iv_ld & cfg_rdy
//  iv_ld      in   1   IV load request (also restarts the chain)
//  enc        in   1   1 encrypt, 0 decrypt; latched per block at acceptance
//  cbc        in   1   1 CBC, 0 ECB; latched per block at acceptance
//  cfg_rdy    out  1   high only in IDLE; key/IV loads are accepted only then
//  din        in   64  input block
//  din_vld    in   1   input block valid
//  din_rdy    out  1   input block accepted when din_vld & din_rdy
//  dout       out  64  output block; held stable while dout_vld & !dout_rdy
//  dout_vld   out  1   output block valid
//  dout_rdy   in   1   downstream ready
//  err        out  1   sticky core-timeout flag; cleared by key_ld
//  core_din   out  64  to core Din (registered)
//  core_key   out  64  to core Key (key register)
//  core_drdy  out  1   to core Drdy; one-cycle pulse
//  core_krdy  out  1   to core Krdy; one-cycle pulse
//  core_enc   out  1   to core ENC; latched enc of the block in flight
//  core_en    out  1   to core EN; constant 1 out of reset
//  core_rstn  out  1   to core RSTn (synchronous in core); registered
//  core_dout  in   64  from core Dout
//  core_bsy   in   1   from core BSY
//  core_dvld  in   1   from core Dvld
// BEHAVIOUR
//  Reset (async): state IDLE; key/IV/chain regs 0; key_ok=0; all outputs 0 except cfg_rdy=1; core_rstn=0, first clock after deassert =1.
//  FSM: IDLE -> KEY | LOAD; KEY -> IDLE; LOAD -> WAIT; WAIT -> OUT | FLUSH; OUT -> IDLE; FLUSH -> IDLE.
//  IDLE: key_ld has priority over iv_ld over din. key_ld: key reg <= key_in, err <= 0, go KEY. iv_ld: chain <= iv_in, stay IDLE.
//  KEY: core_krdy=1 for exactly one cycle (core BSY=0 here); key_ok <= 1.
//  din_rdy = (state==IDLE) & key_ok & !key_ld & !iv_ld. Accept at cycle t: latch enc/cbc/din; core_din <= enc&cbc ? din^chain : din.
//  LOAD (t+1): core_drdy=1 one cycle; core_enc = latched enc. Core BSY high t+2..t+17, Dvld rises t+18.
//  WAIT: ignore core_dvld until core_bsy has been seen high (stale Dvld from previous block); then on core_dvld & !core_bsy:
//   enc: dout <= core_dout; chain <= core_dout (CBC). dec: dout <= core_dout ^ chain (CBC) or core_dout (ECB); chain <= latched din.
//   ECB never modifies chain. dout_vld=1 from t+19 (19-cycle latency; throughput 1 block / 20 cycles with dout_rdy=1).
//  OUT: hold dout/dout_vld until dout_rdy; on handshake dout_vld<=0, go IDLE (next accept possible same cycle as IDLE entry+0).
//  Timeout: WAIT counter > TIMEOUT-1 -> FLUSH: core_rstn=0 one cycle, err<=1, block dropped, chain unchanged, no dout_vld.
//  key_ld/iv_ld while not IDLE: ignored (cfg_rdy=0); requester must hold until accepted. enc/cbc changes mid-block: no effect.
//  Reset mid-block: block lost, chain=0, key_ok=0; key must be reloaded before din_rdy rises.
// TESTING
//  1 ECB enc: key 133457799BBCDFF1, din 0123456789ABCDEF -> dout 85E813540F0AB405, dout_vld exactly 19 cycles after accept.
//  2 CBC enc FIPS-81: key 0123456789ABCDEF, IV 1234567890ABCDEF, din 4E6F772069732074, 68652074696D6520, 666F7220616C6C20
//    -> E5C7CDDE872BF27C, 43E934008C389C0F, 683788499A7C05F6.
//  3 CBC dec of test-2 ciphertexts after iv_ld of same IV -> original plaintexts; dout_rdy=0 for 5 cycles on block 2: dout stable, din_rdy=0.
//  4 Priority: key_ld, iv_ld, din_vld same IDLE cycle -> KEY first, core_krdy one pulse, din accepted only after key_ok and iv load.
//  5 Timeout: core model never raises Dvld -> after TIMEOUT WAIT cycles core_rstn low 1 cycle, err=1, no dout_vld; key_ld clears err.
//  6 Async RSTn asserted at t+10 mid-block -> outputs at reset values immediately, din_rdy=0 until new key loaded.

Source files
------------

// File: rtl/des_cbc_ctrl.sv
// CBC/ECB block sequencer for one iterative 17-cycle DES core.
// Holds key/IV/chain state, does the chaining XORs and recovers from a hung core by timeout.
module des_cbc_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [63:0] key_in,
    input  logic        key_ld,
    input  logic [63:0] iv_in,
    input  logic        iv_ld,
    input  logic        enc,
    input  logic        cbc,
    output logic        cfg_rdy,
    input  logic [63:0] din,
    input  logic        din_vld,
    output logic        din_rdy,
    output logic [63:0] dout,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic        err,
    output logic [63:0] core_din,
    output logic [63:0] core_key,
    output logic        core_drdy,
    output logic        core_krdy,
    output logic        core_enc,
    output logic        core_en,
    output logic        core_rstn,
    input  logic [63:0] core_dout,
    input  logic        core_bsy,
    input  logic        core_dvld,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t state, next_state;

    logic [63:0]      key_r, chain_r, din_r, core_din_r, dout_r;
    logic             key_ok, enc_r, cbc_r, dout_vld_r, err_r, core_rstn_r, core_en_r;
    logic             bsy_seen;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept, core_done, timed_out;

    // Handshakes: a transfer happens on a rising CLK edge where both valid and ready are high.
    assign accept    = (state == S_IDLE) && key_ok && !key_ld && !iv_ld && din_vld;
    // A Dvld left over from the previous block is ignored until BSY has been seen for this one.
    assign core_done = (state == S_WAIT) && bsy_seen && core_dvld && !core_bsy;
    assign timed_out = (state == S_WAIT) && !core_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (key_ld)      next_state = S_KEY;
                else if (iv_ld)  next_state = S_IDLE;
                else if (accept) next_state = S_LOAD;
            end
            S_KEY:   next_state = S_IDLE;
            S_LOAD:  next_state = S_WAIT;
            S_WAIT: begin
                if (core_done)      next_state = S_OUT;
                else if (timed_out) next_state = S_FLUSH;
            end
            S_OUT:   if (dout_rdy) next_state = S_IDLE;
            S_FLUSH: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_rdy   = (state == S_IDLE);
        din_rdy   = (state == S_IDLE) && key_ok && !key_ld && !iv_ld;
        core_drdy = (state == S_LOAD);
        core_krdy = (state == S_KEY);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_r       <= '0;
            chain_r     <= '0;
            din_r       <= '0;
            core_din_r  <= '0;
            dout_r      <= '0;
            key_ok      <= 1'b0;
            enc_r       <= 1'b0;
            cbc_r       <= 1'b0;
            dout_vld_r  <= 1'b0;
            err_r       <= 1'b0;
            core_rstn_r <= 1'b0;
            core_en_r   <= 1'b0;
            bsy_seen    <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            core_en_r   <= 1'b1;
            core_rstn_r <= (next_state != S_FLUSH);
            if (state == S_IDLE && key_ld) begin
                key_r <= key_in;
                err_r <= 1'b0;
            end else if (state == S_IDLE && iv_ld) begin
                chain_r <= iv_in;
            end
            if (state == S_KEY) key_ok <= 1'b1;
            if (accept) begin
                enc_r      <= enc;
                cbc_r      <= cbc;
                din_r      <= din;
                core_din_r <= (enc && cbc) ? (din ^ chain_r) : din;
            end
            if (state == S_LOAD) begin
                wait_cnt <= '0;
                bsy_seen <= 1'b0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (core_bsy) bsy_seen <= 1'b1;
            end
            if (core_done) begin
                dout_vld_r <= 1'b1;
                if (enc_r) begin
                    dout_r <= core_dout;
                    if (cbc_r) chain_r <= core_dout;
                end else begin
                    dout_r <= cbc_r ? (core_dout ^ chain_r) : core_dout;
                    if (cbc_r) chain_r <= din_r;
                end
            end
            if (timed_out) err_r <= 1'b1;
            if (state == S_OUT && dout_rdy) dout_vld_r <= 1'b0;
        end
    end

    assign dout      = dout_r;
    assign dout_vld  = dout_vld_r;
    assign err       = err_r;
    assign core_din  = core_din_r;
    assign core_key  = key_r;
    assign core_enc  = enc_r;
    assign core_en   = core_en_r;
    assign core_rstn = core_rstn_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Self-checking bench for des_cbc_ctrl with a behavioural 17-cycle DES core
// and a block-level CBC/ECB reference model.
module tb_des_cbc_ctrl;

    localparam int TIMEOUT = 32;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [63:0] key_in, iv_in, din;
    logic        key_ld, iv_ld, enc, cbc, din_vld, dout_rdy;
    logic        cfg_rdy, din_rdy, dout_vld, err;
    logic [63:0] dout, core_din, core_key;
    logic        core_drdy, core_krdy, core_enc, core_en, core_rstn;
    logic [63:0] core_dout = '0;
    logic        core_bsy = 1'b0, core_dvld = 1'b0;
    logic [2:0]  dbg_state;

    des_cbc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .key_ld(key_ld), .iv_in(iv_in), .iv_ld(iv_ld),
        .enc(enc), .cbc(cbc), .cfg_rdy(cfg_rdy), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .err(err), .core_din(core_din),
        .core_key(core_key), .core_drdy(core_drdy), .core_krdy(core_krdy), .core_enc(core_enc),
        .core_en(core_en), .core_rstn(core_rstn), .core_dout(core_dout), .core_bsy(core_bsy),
        .core_dvld(core_dvld), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DES tables, positions numbered 1..n from the MSB.
    int ip_t[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int e_t[48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int pc1_t[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                      19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sb_t[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] blk, input logic encrypt);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks[16];
        logic [47:0] x;
        logic [63:0] ipv, pre, res;
        logic [31:0] l, r, f, sout, tmp;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int s = 0; s < sh_t[rd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-pc2_t[i]];
        end
        for (int i = 0; i < 64; i++) ipv[63-i] = blk[64-ip_t[i]];
        l = ipv[63:32];
        r = ipv[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int i = 0; i < 48; i++) x[47-i] = r[32-e_t[i]];
            x = x ^ (encrypt ? ks[rd] : ks[15-rd]);
            for (int s = 0; s < 8; s++) begin
                six = x[47-6*s -: 6];
                idx = s * 64 + int'({six[5], six[0]}) * 16 + int'(six[4:1]);
                sout[31-4*s -: 4] = 4'(sb_t[idx]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = sout[32-p_t[i]];
            tmp = r;
            r = l ^ f;
            l = tmp;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-fp_t[i]];
        return res;
    endfunction

    // Behavioural DES core: BSY for 16 cycles after Drdy, then Dvld held until the next Drdy.
    logic        hang = 1'b0;
    logic [63:0] core_k = '0, core_res = '0;
    int          busy_cnt = 0;
    int          krdy_cnt = 0;

    always @(posedge CLK) begin
        if (core_krdy) krdy_cnt <= krdy_cnt + 1;
        if (!core_rstn) begin
            core_bsy  <= 1'b0;
            core_dvld <= 1'b0;
            busy_cnt  <= 0;
        end else begin
            if (core_krdy) core_k <= core_key;
            if (core_drdy && !core_bsy) begin
                core_bsy  <= 1'b1;
                core_dvld <= 1'b0;
                busy_cnt  <= 16;
                core_res  <= des(core_k, core_din, core_enc);
            end else if (core_bsy) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    core_bsy  <= 1'b0;
                    core_dvld <= !hang;
                    core_dout <= core_res;
                end
            end
        end
    end

    // Block-level reference: key, chain value and expected output queue.
    logic [63:0] m_key = '0, m_chain = '0;
    logic [63:0] exp_q[$];

    task automatic model_block(input logic [63:0] d, input logic e, input logic c);
        logic [63:0] r;
        if (c && e) begin
            r = des(m_key, d ^ m_chain, 1'b1);
            m_chain = r;
        end else if (c) begin
            r = des(m_key, d, 1'b0) ^ m_chain;
            m_chain = d;
        end else begin
            r = des(m_key, d, e);
        end
        exp_q.push_back(r);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [63:0] k);
        int n = 0;
        key_in = k;
        key_ld = 1'b1;
        @(negedge CLK);
        while (!cfg_rdy && n < 100) begin @(negedge CLK); n++; end
        check("key_accept", {63'd0, cfg_rdy}, 64'd1);
        @(posedge CLK); #1;
        key_ld = 1'b0;
        m_key = k;
    endtask

    task automatic load_iv(input logic [63:0] v);
        int n = 0;
        iv_in = v;
        iv_ld = 1'b1;
        @(negedge CLK);
        while (!cfg_rdy && n < 100) begin @(negedge CLK); n++; end
        check("iv_accept", {63'd0, cfg_rdy}, 64'd1);
        @(posedge CLK); #1;
        iv_ld = 1'b0;
        m_chain = v;
    endtask

    task automatic run_block(input logic [63:0] d, input logic e, input logic c, input int stall,
                             output logic [63:0] got, output int acc);
        int n = 0;
        logic [63:0] exp, held;
        din = d; enc = e; cbc = c; din_vld = 1'b1;
        dout_rdy = (stall == 0);
        @(negedge CLK);
        while (!din_rdy && n < 100) begin @(negedge CLK); n++; end
        check("din_accept", {63'd0, din_rdy}, 64'd1);
        @(posedge CLK); #1;
        acc = cyc;
        din_vld = 1'b0; enc = ~e; cbc = ~c; din = ~d;
        model_block(d, e, c);
        n = 1;
        @(negedge CLK);
        while (!dout_vld && n < 60) begin @(negedge CLK); n++; end
        check("latency", 64'(n), 64'd19);
        exp = exp_q.pop_front();
        check("dout", dout, exp);
        got = dout;
        held = dout;
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            check("dout_hold", dout, held);
            check("vld_hold", {63'd0, dout_vld}, 64'd1);
            check("din_rdy_stall", {63'd0, din_rdy}, 64'd0);
        end
        dout_rdy = 1'b1;
        @(posedge CLK); #1;
        check("vld_drop", {63'd0, dout_vld}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] got, k, v, d;
        logic [63:0] ct[3];
        logic [63:0] pt[3];
        int acc, acc_prev, n;
        logic seen_vld;

        RSTn = 1'b0; key_in = '0; key_ld = 0; iv_in = '0; iv_ld = 0;
        enc = 0; cbc = 0; din = '0; din_vld = 0; dout_rdy = 1;
        #1;
        check("rst_cfg_rdy", {63'd0, cfg_rdy}, 64'd1);
        check("rst_din_rdy", {63'd0, din_rdy}, 64'd0);
        check("rst_dout_vld", {63'd0, dout_vld}, 64'd0);
        check("rst_core_rstn", {63'd0, core_rstn}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_pulses", {62'd0, core_drdy, core_krdy}, 64'd0);
        #21 RSTn = 1'b1;
        @(negedge CLK);
        check("core_rstn_up", {63'd0, core_rstn}, 64'd1);
        check("core_en_up", {63'd0, core_en}, 64'd1);

        // No key loaded: din must not be accepted.
        din_vld = 1'b1;
        repeat (3) @(negedge CLK);
        check("no_key_din_rdy", {63'd0, din_rdy}, 64'd0);
        din_vld = 1'b0;

        // ECB encrypt, classic vector.
        load_key(64'h133457799BBCDFF1);
        run_block(64'h0123456789ABCDEF, 1'b1, 1'b0, 0, got, acc);
        check("ecb_vector", got, 64'h85E813540F0AB405);

        // CBC encrypt, FIPS-81.
        pt[0] = 64'h4E6F772069732074; pt[1] = 64'h68652074696D6520; pt[2] = 64'h666F7220616C6C20;
        ct[0] = 64'hE5C7CDDE872BF27C; ct[1] = 64'h43E934008C389C0F; ct[2] = 64'h683788499A7C05F6;
        load_key(64'h0123456789ABCDEF);
        load_iv(64'h1234567890ABCDEF);
        for (int i = 0; i < 3; i++) begin
            acc_prev = acc;
            run_block(pt[i], 1'b1, 1'b1, 0, got, acc);
            check("fips_enc", got, ct[i]);
            if (i > 0) check("throughput", 64'(acc - acc_prev), 64'd20);
        end

        // CBC decrypt with a stall on block 2.
        load_iv(64'h1234567890ABCDEF);
        for (int i = 0; i < 3; i++) begin
            run_block(ct[i], 1'b0, 1'b1, (i == 1) ? 5 : 0, got, acc);
            check("fips_dec", got, pt[i]);
        end

        // key_ld, iv_ld and din_vld raised together.
        k = {$urandom, $urandom}; v = {$urandom, $urandom}; d = {$urandom, $urandom};
        key_in = k; iv_in = v; din = d; enc = 1; cbc = 1;
        key_ld = 1; iv_ld = 1; din_vld = 1;
        n = krdy_cnt;
        @(negedge CLK);
        check("prio_idle_din_rdy", {62'd0, cfg_rdy, din_rdy}, 64'd2);
        @(posedge CLK); #1; key_ld = 0; m_key = k;
        @(negedge CLK);
        check("prio_key_state", {61'd0, core_krdy, cfg_rdy, din_rdy}, 64'd4);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("prio_iv_wait", {61'd0, core_krdy, cfg_rdy, din_rdy}, 64'd2);
        @(posedge CLK); #1; iv_ld = 0; m_chain = v;
        @(negedge CLK);
        check("prio_din_rdy", {63'd0, din_rdy}, 64'd1);
        check("prio_krdy_pulses", 64'(krdy_cnt - n), 64'd1);
        din_vld = 0;
        @(posedge CLK); #1;
        run_block(d, 1'b1, 1'b1, 0, got, acc);

        // Randomised mix of modes, stalls, keys and IVs.
        load_key({$urandom, $urandom});
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) load_iv({$urandom, $urandom});
            run_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), got, acc);
        end

        // Hung core: timeout flush, then key reload clears err.
        hang = 1'b1;
        din = {$urandom, $urandom}; enc = 1; cbc = 1; din_vld = 1;
        n = 0;
        @(negedge CLK);
        while (!din_rdy && n < 100) begin @(negedge CLK); n++; end
        @(posedge CLK); #1;
        din_vld = 0;
        n = 1; seen_vld = 0;
        @(negedge CLK);
        while (core_rstn && n < 80) begin
            if (dout_vld) seen_vld = 1;
            @(negedge CLK);
            n++;
        end
        check("flush_cycle", 64'(n), 64'(TIMEOUT + 2));
        check("flush_err", {63'd0, err}, 64'd1);
        @(negedge CLK);
        check("flush_one_cycle", {63'd0, core_rstn}, 64'd1);
        repeat (3) begin
            if (dout_vld) seen_vld = 1;
            @(negedge CLK);
        end
        check("flush_no_vld", {63'd0, seen_vld}, 64'd0);
        hang = 1'b0;
        @(posedge CLK); #1;
        load_key(m_key);
        check("err_cleared", {63'd0, err}, 64'd0);
        run_block({$urandom, $urandom}, 1'b1, 1'b1, 0, got, acc);

        // Asynchronous reset in the middle of a block.
        din = {$urandom, $urandom}; enc = 1; cbc = 1; din_vld = 1;
        n = 0;
        @(negedge CLK);
        while (!din_rdy && n < 100) begin @(negedge CLK); n++; end
        @(posedge CLK); #1;
        din_vld = 0;
        repeat (9) @(posedge CLK);
        #2 RSTn = 1'b0;
        #1;
        check("mid_rst_dout_vld", {63'd0, dout_vld}, 64'd0);
        check("mid_rst_rdys", {62'd0, cfg_rdy, din_rdy}, 64'd2);
        check("mid_rst_core", {61'd0, core_rstn, core_drdy, core_krdy}, 64'd0);
        check("mid_rst_key", core_key, 64'd0);
        check("mid_rst_core_din", core_din, 64'd0);
        m_chain = '0;
        @(posedge CLK); #2 RSTn = 1'b1;
        din_vld = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("post_rst_din_rdy", {63'd0, din_rdy}, 64'd0);
        end
        din_vld = 1'b0;
        @(posedge CLK); #1;
        load_key({$urandom, $urandom});
        run_block({$urandom, $urandom}, 1'b1, 1'b1, 0, got, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
